// File: rtl/grayscale.sv
// RGB-to-gray conversion stage feeding the Sobel filter.
// Two-stage pipeline (sum, divide) with full backpressure and a one-frame pixel budget.
module grayscale #(
    parameter int IMG_HEIGHT = 540,
    parameter int IMG_WIDTH  = 720
) (
    input  logic        clock,
    input  logic        reset,
    output logic        rgb_rd_en,
    input  logic        rgb_empty,
    input  logic [23:0] rgb_dout,
    output logic        gray_wr_en,
    input  logic        gray_full,
    output logic [7:0]  gray_din,
    output logic        done
);

    localparam int NUM_PIXELS = IMG_HEIGHT * IMG_WIDTH;
    localparam int CNT_W      = $clog2(NUM_PIXELS + 1);
    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(NUM_PIXELS);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(NUM_PIXELS - 1);

    function automatic logic [9:0] sum_rgb(input logic [23:0] px);
        return {2'b00, px[23:16]} + {2'b00, px[15:8]} + {2'b00, px[7:0]};
    endfunction

    // Truncating divide; the 765 ceiling guarantees the quotient fits in 8 bits.
    function automatic logic [7:0] div3(input logic [9:0] s);
        return 8'(s / 10'd3);
    endfunction

    logic             vld_p1;
    logic [9:0]       sum_p1;
    logic             vld_p2;
    logic [7:0]       gray_p2;
    logic [CNT_W-1:0] rd_count;
    logic [CNT_W-1:0] wr_count;
    logic             s2_load;

    assign gray_wr_en = vld_p2 & ~gray_full;
    assign gray_din   = vld_p2 ? gray_p2 : 8'd0;
    assign s2_load    = vld_p1 & (~vld_p2 | gray_wr_en);
    // Gated by reset so no pop is requested while the pipeline is held in reset.
    assign rgb_rd_en  = reset & ~rgb_empty & ~done & (rd_count < FRAME_CNT)
                        & (~vld_p1 | s2_load);

    // Stage 1: pop and sum the three channels
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_p1 <= 1'b0;
            sum_p1 <= '0;
        end else if (rgb_rd_en) begin
            vld_p1 <= 1'b1;
            sum_p1 <= sum_rgb(rgb_dout);
        end else if (s2_load) begin
            vld_p1 <= 1'b0;
        end
    end

    // Stage 2: divide by three and hold until the gray FIFO accepts it
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_p2  <= 1'b0;
            gray_p2 <= '0;
        end else if (s2_load) begin
            vld_p2  <= 1'b1;
            gray_p2 <= div3(sum_p1);
        end else if (gray_wr_en) begin
            vld_p2 <= 1'b0;
        end
    end

    // Frame accounting; reads stop at the frame size so neither counter can wrap
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_count <= '0;
            wr_count <= '0;
            done     <= 1'b0;
        end else begin
            if (rgb_rd_en) rd_count <= rd_count + 1'b1;
            if (gray_wr_en) begin
                wr_count <= wr_count + 1'b1;
                if (wr_count == LAST_CNT) done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_grayscale.sv
// Directed plus randomized bench for grayscale on a 4x3 frame, with FIFO
// models and a plain-arithmetic luminance reference.
module tb_grayscale;

    localparam int H = 3;
    localparam int W = 4;
    localparam int N = H * W;

    logic        clock;
    logic        reset;
    logic        rgb_rd_en;
    logic        rgb_empty;
    logic [23:0] rgb_dout;
    logic        gray_wr_en;
    logic        gray_full;
    logic [7:0]  gray_din;
    logic        done;

    grayscale #(.IMG_HEIGHT(H), .IMG_WIDTH(W)) dut (
        .clock      (clock),
        .reset      (reset),
        .rgb_rd_en  (rgb_rd_en),
        .rgb_empty  (rgb_empty),
        .rgb_dout   (rgb_dout),
        .gray_wr_en (gray_wr_en),
        .gray_full  (gray_full),
        .gray_din   (gray_din),
        .done       (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [23:0] src_q[$];
    logic [23:0] frame_px[$];
    logic [7:0]  got_q[$];
    int          checks = 0;
    int          failures = 0;
    int          rd_total = 0;
    int          wr_total = 0;
    logic        s_rd, s_wr, s_done;
    logic [7:0]  s_din;
    logic [7:0]  held;

    function automatic int gray_ref(input logic [23:0] p);
        return (int'(p[23:16]) + int'(p[15:8]) + int'(p[7:0])) / 3;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic update_inputs();
        rgb_empty = (src_q.size() == 0);
        rgb_dout  = (src_q.size() != 0) ? src_q[0] : 24'h0;
    endtask

    task automatic push(input logic [23:0] p);
        src_q.push_back(p);
        frame_px.push_back(p);
        update_inputs();
    endtask

    task automatic clear_env();
        src_q.delete();
        frame_px.delete();
        got_q.delete();
        rd_total = 0;
        wr_total = 0;
        update_inputs();
    endtask

    // One clock: sample the handshake mid-cycle, then apply the FIFO effects after the edge.
    task automatic tick();
        @(negedge clock);
        s_rd   = rgb_rd_en;
        s_wr   = gray_wr_en;
        s_din  = gray_din;
        s_done = done;
        @(posedge clock);
        #1;
        if (s_wr) begin
            got_q.push_back(s_din);
            wr_total++;
        end
        if (s_rd) begin
            src_q.delete(0);
            rd_total++;
        end
        update_inputs();
    endtask

    task automatic run_to_done();
        int n;
        n = 0;
        while (!done && n < 200) begin
            tick();
            n++;
        end
        check("done_reached", 32'(done), 32'd1);
    endtask

    task automatic check_frame(input string tag);
        check({tag, "_count"}, 32'(got_q.size()), 32'(N));
        for (int i = 0; i < N; i++) begin
            if (i < got_q.size())
                check({tag, "_px"}, 32'(got_q[i]), 32'(gray_ref(frame_px[i])));
        end
    endtask

    initial begin
        reset     = 1'b0;
        gray_full = 1'b0;
        clear_env();

        // Reset with a pixel waiting: nothing may be popped or pushed
        push(24'h1E3C5A);
        tick();
        tick();
        check("rst_rd_en", 32'(rgb_rd_en), 32'd0);
        check("rst_wr_en", 32'(gray_wr_en), 32'd0);
        check("rst_din", 32'(gray_din), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_no_pop", 32'(rd_total), 32'd0);

        // Single pixel latency: read at N, write at N+2
        reset = 1'b1;
        tick();
        check("first_read", 32'(s_rd), 32'd1);
        tick();
        check("lat_n1_wr", 32'(s_wr), 32'd0);
        tick();
        check("lat_n2_wr", 32'(s_wr), 32'd1);
        check("lat_n2_din", 32'(s_din), 32'd60);

        // Extremes followed by random pixels to fill the frame
        push(24'hFFFFFF);
        push(24'h000000);
        push(24'h010100);
        push(24'h020201);
        for (int i = 0; i < 7; i++) push(24'($urandom()));
        for (int i = 0; i < 4; i++) tick();

        // Backpressure with both stages occupied
        gray_full = 1'b1;
        tick();
        check("bp_wr_en", 32'(s_wr), 32'd0);
        check("bp_rd_drop", 32'(s_rd), 32'd0);
        held = s_din;
        check("bp_held_val", 32'(held), 32'(gray_ref(frame_px[wr_total])));
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bp_hold_wr", 32'(s_wr), 32'd0);
            check("bp_hold_rd", 32'(s_rd), 32'd0);
            check("bp_hold_din", 32'(s_din), 32'(held));
        end
        gray_full = 1'b0;
        tick();
        check("bp_resume", 32'(s_wr), 32'd1);
        run_to_done();
        check_frame("frame1");
        check("ext_ff", 32'(got_q.size() > 1 ? got_q[1] : 8'hxx), 32'd255);
        check("ext_00", 32'(got_q.size() > 2 ? got_q[2] : 8'hxx), 32'd0);
        check("ext_trunc0", 32'(got_q.size() > 3 ? got_q[3] : 8'hxx), 32'd0);
        check("ext_trunc1", 32'(got_q.size() > 4 ? got_q[4] : 8'hxx), 32'd1);
        check("frame1_reads", 32'(rd_total), 32'(N));

        // Frame limit: 14 queued, exactly 12 consumed
        reset = 1'b0;
        clear_env();
        for (int i = 0; i < N + 2; i++) push(24'($urandom()));
        @(posedge clock);
        #1;
        reset = 1'b1;
        begin
            int n;
            n = 0;
            while (wr_total < N && n < 200) begin
                tick();
                n++;
            end
        end
        check("lim_writes_seen", 32'(wr_total), 32'(N));
        check("lim_done_before", 32'(s_done), 32'd0);
        check("lim_done_after", 32'(done), 32'd1);
        for (int i = 0; i < 3; i++) tick();
        check("lim_reads", 32'(rd_total), 32'(N));
        check("lim_writes", 32'(wr_total), 32'(N));
        check("lim_left", 32'(src_q.size()), 32'd2);
        check("lim_rd_en", 32'(rgb_rd_en), 32'd0);
        check("lim_done_sticky", 32'(done), 32'd1);
        check_frame("frame2");

        // Reset mid-frame, then a clean rerun
        reset = 1'b0;
        clear_env();
        @(posedge clock);
        #1;
        reset = 1'b1;
        for (int i = 0; i < N; i++) push(24'($urandom()));
        begin
            int n;
            n = 0;
            while (rd_total < 6 && n < 100) begin
                tick();
                n++;
            end
        end
        check("mid_reads", 32'(rd_total), 32'd6);
        #3;
        reset = 1'b0;
        #1;
        check("mid_rst_rd_en", 32'(rgb_rd_en), 32'd0);
        check("mid_rst_wr_en", 32'(gray_wr_en), 32'd0);
        check("mid_rst_din", 32'(gray_din), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        clear_env();
        for (int i = 0; i < N; i++) push(24'($urandom()));
        @(posedge clock);
        #1;
        reset = 1'b1;
        run_to_done();
        check_frame("frame3");
        check("frame3_reads", 32'(rd_total), 32'(N));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
